regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Write-port arbiter and sequencer for the 32x64 register file in the multi-cycle core. Two write-back sources share the register file's single write port: A (ALU/execute result) and B (load/memory result). Arbitration is round-robin with a valid/ready handshake. The block drives a registered write strobe/address/data toward the register file and reports, for two read addresses, whether a write is in flight to them (forwarding hints).

Parameters:
ADDRESS_LEN  5   register address width; file depth 2**ADDRESS_LEN
N            64  data width

Ports:
clk        input   1            clock; all state updates on rising edge
rst        input   1            synchronous, active-high reset
wr_stall   input   1            1 = register file must not be written this cycle; no grants
a_valid    input   1            source A request
a_addr     input   ADDRESS_LEN  source A destination register
a_data     input   N            source A write data
a_ready    output  1            source A grant (combinational)
b_valid    input   1            source B request
b_addr     input   ADDRESS_LEN  source B destination register
b_data     input   N            source B write data
b_ready    output  1            source B grant (combinational)
rf_wr_en   output  1            registered write strobe to register file
rf_wr_addr output  ADDRESS_LEN  registered write address
rf_wr_data output  N            registered write data
chk_addr_1 input   ADDRESS_LEN  read-port 1 address to check
chk_addr_2 input   ADDRESS_LEN  read-port 2 address to check
fwd_hit_1  output  1            rf_wr_en & rf_wr_addr==chk_addr_1 & chk_addr_1!=0
fwd_hit_2  output  1            same for port 2

Behaviour:
- Reset (rst=1 at edge): rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, last_grant=B (so A wins the first conflict). a_ready/b_ready=0 while rst=1. rst mid-transfer drops any captured write: rf_wr_en=0 the next cycle and no register file write occurs.
- Grant logic (combinational): if wr_stall=1, both ready=0. Else if exactly one valid, that source is granted. If both are valid, the source not equal to last_grant is granted. Ready is never asserted without valid.
- Handshake: a transfer occurs when valid&ready. Source holds valid/addr/data stable until ready. A source may drop valid without a transfer; no penalty.
- last_grant updates only on a transfer, to the granted source.
- Capture: on a transfer, next cycle rf_wr_en=1, rf_wr_addr/rf_wr_data = granted source's addr/data. Latency is exactly 1 cycle; throughput is 1 write/cycle.
- No transfer: next cycle rf_wr_en=0; rf_wr_addr/rf_wr_data hold their previous values.
- x0 writes: addr==0 is accepted (ready asserted, last_grant updated), but rf_wr_en stays 0 next cycle; addr/data still update.
- wr_stall=1: no transfer that cycle. An already-registered write (rf_wr_en=1) still completes; it is not extended or replayed.
- Both sources targeting the same address: the winner writes at T+1, the loser at T+2 (if it keeps valid). The final register value is the loser's.
- fwd_hit_* is purely combinational from the registered output stage and the chk inputs.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs conflict_cnt[15:0] and stall_cnt[15:0].
  - conflict_cnt increments each cycle with a_valid&b_valid&~wr_stall.
  - stall_cnt increments each cycle with wr_stall&(a_valid|b_valid).
  - Both saturate at 16'hFFFF and are cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0; after release the first conflict grants A.
2. a_valid=1, a_addr=5, a_data=64'hDEAD at cycle T, b_valid=0 -> a_ready=1 at T; at T+1 rf_wr_en=1, rf_wr_addr=5, rf_wr_data=64'hDEAD; at T+2 rf_wr_en=0.
3. A and B both valid for 4 cycles (addrs 3/4, data 1/2, refreshed each cycle) -> grants alternate A,B,A,B; write stream addr 3,4,3,4.
4. Same-address conflict, a_addr=b_addr=7, a_data=11, b_data=22 -> writes at T+1 (11), T+2 (22); chk_addr_1=7 gives fwd_hit_1=1 at T+1 and T+2.
5. a_addr=0, a_data=99 -> a_ready=1, rf_wr_en=0 next cycle; chk_addr_1=0 -> fwd_hit_1=0; next conflict grants B.
6. wr_stall=1 for 3 cycles with both valid -> no ready, rf_wr_en=0 after the in-flight write. With ARB_STATS_EN: stall_cnt=3, conflict_cnt=0; on release, the write of the source not equal to last_grant appears 1 cycle later.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Write-back bus between the two write sources, the arbiter and the register file.
// Carries both request handshakes, the registered write stage and the forwarding-check lanes.
// master = source/regfile side (drives requests and check addresses), slave = the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int ADDRESS_LEN = 5,
  parameter int N           = 64
);
  logic                   wr_stall;
  logic                   a_valid;
  logic [ADDRESS_LEN-1:0] a_addr;
  logic [N-1:0]           a_data;
  logic                   a_ready;
  logic                   b_valid;
  logic [ADDRESS_LEN-1:0] b_addr;
  logic [N-1:0]           b_data;
  logic                   b_ready;
  logic                   rf_wr_en;
  logic [ADDRESS_LEN-1:0] rf_wr_addr;
  logic [N-1:0]           rf_wr_data;
  logic [ADDRESS_LEN-1:0] chk_addr_1;
  logic [ADDRESS_LEN-1:0] chk_addr_2;
  logic                   fwd_hit_1;
  logic                   fwd_hit_2;

  modport master (
    output wr_stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
           chk_addr_1, chk_addr_2,
    input  a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_hit_1, fwd_hit_2
  );

  modport slave (
    input  wr_stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
           chk_addr_1, chk_addr_2,
    output a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_hit_1, fwd_hit_2
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port (A = ALU, B = load), with forwarding hints.
// Latency: grant is combinational, write appears on rf_wr_* exactly 1 cycle after the transfer.
// Backpressure: wr_stall or rst withholds both readys; the losing source simply waits with valid held.
// Optional build macro ARB_STATS_EN adds saturating conflict_cnt / stall_cnt outputs.
module regfile_wr_arbiter #(
  parameter int ADDRESS_LEN = 5,
  parameter int N           = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          conflict_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e                   last_grant;
  src_e                   last_grant_nxt;
  logic                   grant_a;
  logic                   grant_b;
  logic                   wr_en_q;
  logic [ADDRESS_LEN-1:0] wr_addr_q;
  logic [N-1:0]           wr_data_q;

  // Round-robin pointer: remembers who won the most recent transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_B;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // Grant selection: stall/reset block all grants, a lone requester wins, a conflict goes to the other source.
  always_comb begin
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    last_grant_nxt = last_grant;
    if (!rst && !bus.wr_stall) begin
      if (bus.a_valid && bus.b_valid) begin
        if (last_grant == SRC_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else if (bus.a_valid) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      last_grant_nxt = SRC_A;
    end else if (grant_b) begin
      last_grant_nxt = SRC_B;
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Write stage: capture the granted request; x0 targets update addr/data but never strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (grant_a) begin
      wr_en_q   <= (bus.a_addr != '0);
      wr_addr_q <= bus.a_addr;
      wr_data_q <= bus.a_data;
    end else if (grant_b) begin
      wr_en_q   <= (bus.b_addr != '0);
      wr_addr_q <= bus.b_addr;
      wr_data_q <= bus.b_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  assign bus.rf_wr_en   = wr_en_q;
  assign bus.rf_wr_addr = wr_addr_q;
  assign bus.rf_wr_data = wr_data_q;

  // Forwarding hints: a strobed write in the output stage matches a non-x0 read address.
  assign bus.fwd_hit_1 = wr_en_q && (wr_addr_q == bus.chk_addr_1) && (bus.chk_addr_1 != '0);
  assign bus.fwd_hit_2 = wr_en_q && (wr_addr_q == bus.chk_addr_2) && (bus.chk_addr_2 != '0);

`ifdef ARB_STATS_EN
  // Saturating event counters for conflicts seen by the arbiter and requests blocked by stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (bus.a_valid && bus.b_valid && !bus.wr_stall && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (bus.wr_stall && (bus.a_valid || bus.b_valid) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected write-stage contents are queued per step and popped after the edge.
// Inputs change on the falling edge, readys are sampled 1 time unit later, outputs 1 unit after the rising edge.
// Build with ARB_STATS_EN defined to also check the stall/conflict counters.
module tb_regfile_wr_arbiter;
  localparam int AL = 5;
  localparam int DW = 64;

  typedef struct packed {
    logic          en;
    logic [AL-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  wr_t  sb[$];
  logic [AL-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.ADDRESS_LEN(AL), .N(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic [15:0] stall_cnt;
`endif

  regfile_wr_arbiter #(.ADDRESS_LEN(AL), .N(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus with the grant the spec requires; pushes the resulting write-stage state.
  task automatic step(input string tag, input logic r, input logic st,
                      input logic av, input logic [AL-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AL-1:0] ba, input logic [DW-1:0] bd,
                      input logic ea, input logic eb);
    wr_t e;
    logic h1;
    logic h2;
    @(negedge clk);
    rst          = r;
    bus.wr_stall = st;
    bus.a_valid  = av;
    bus.a_addr   = aa;
    bus.a_data   = ad;
    bus.b_valid  = bv;
    bus.b_addr   = ba;
    bus.b_data   = bd;
    #1;
    check({tag, ".a_ready"}, DW'(bus.a_ready), DW'(ea));
    check({tag, ".b_ready"}, DW'(bus.b_ready), DW'(eb));
    if (r) begin
      m_addr = '0;
      m_data = '0;
      sb.push_back({1'b0, m_addr, m_data});
    end else if (ea) begin
      m_addr = aa;
      m_data = ad;
      sb.push_back({(aa != '0), aa, ad});
    end else if (eb) begin
      m_addr = ba;
      m_data = bd;
      sb.push_back({(ba != '0), ba, bd});
    end else begin
      sb.push_back({1'b0, m_addr, m_data});
    end
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    h1 = e.en && (e.addr == bus.chk_addr_1) && (bus.chk_addr_1 != '0);
    h2 = e.en && (e.addr == bus.chk_addr_2) && (bus.chk_addr_2 != '0);
    check({tag, ".rf_wr_en"},   DW'(bus.rf_wr_en),   DW'(e.en));
    check({tag, ".rf_wr_addr"}, DW'(bus.rf_wr_addr), DW'(e.addr));
    check({tag, ".rf_wr_data"}, bus.rf_wr_data,      e.data);
    check({tag, ".fwd_hit_1"},  DW'(bus.fwd_hit_1),  DW'(h1));
    check({tag, ".fwd_hit_2"},  DW'(bus.fwd_hit_2),  DW'(h2));
  endtask

  initial begin
    rst            = 1'b1;
    bus.wr_stall   = 1'b0;
    bus.a_valid    = 1'b0;
    bus.a_addr     = '0;
    bus.a_data     = '0;
    bus.b_valid    = 1'b0;
    bus.b_addr     = '0;
    bus.b_data     = '0;
    bus.chk_addr_1 = '0;
    bus.chk_addr_2 = '0;

    // Reset with both sources requesting: no grants, cleared write stage.
    step("rst0", 1, 0, 1, 5'd1, 64'h10, 1, 5'd2, 64'h20, 0, 0);
    step("rst1", 1, 0, 1, 5'd1, 64'h10, 1, 5'd2, 64'h20, 0, 0);
    // First conflict after reset goes to A.
    step("first_conflict", 0, 0, 1, 5'd1, 64'h10, 1, 5'd2, 64'h20, 1, 0);

    // Single A write, then idle: strobe drops, addr/data hold.
    bus.chk_addr_1 = 5'd5;
    step("a_only", 0, 0, 1, 5'd5, 64'hDEAD, 0, 5'd0, 64'h0, 1, 0);
    step("a_idle", 0, 0, 0, 5'd5, 64'hDEAD, 0, 5'd0, 64'h0, 0, 0);

    // Lone B write leaves B as last winner so the next conflicts start with A.
    step("b_only", 0, 0, 0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 1);

    // Sustained conflict alternates A,B,A,B.
    bus.chk_addr_2 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("alt%0d", i), 0, 0, 1, 5'd3, 64'd1, 1, 5'd4, 64'd2, (i % 2) == 0, (i % 2) == 1);
    end

    // Same destination: A writes first, B (still valid) follows; both cycles hit forwarding port 1.
    bus.chk_addr_1 = 5'd7;
    step("same_addr_a", 0, 0, 1, 5'd7, 64'd11, 1, 5'd7, 64'd22, 1, 0);
    step("same_addr_b", 0, 0, 0, 5'd7, 64'd11, 1, 5'd7, 64'd22, 0, 1);
    step("same_addr_idle", 0, 0, 0, 5'd0, 64'd0, 0, 5'd0, 64'd0, 0, 0);

    // x0 write is accepted without a strobe and counts as A's turn.
    bus.chk_addr_1 = 5'd0;
    step("x0_write", 0, 0, 1, 5'd0, 64'd99, 0, 5'd0, 64'd0, 1, 0);
    step("x0_next_conflict", 0, 0, 1, 5'd1, 64'h111, 1, 5'd2, 64'h222, 0, 1);
    bus.chk_addr_1 = 5'd1;
    step("a_after_b", 0, 0, 1, 5'd1, 64'h111, 0, 5'd0, 64'd0, 1, 0);

    // Reset while a write is in the output stage drops it.
    step("rst_mid", 1, 0, 1, 5'd12, 64'h12, 0, 5'd0, 64'd0, 0, 0);

    // Stall: in-flight write completes once, no grants for 3 cycles, then the non-last source wins.
    bus.chk_addr_1 = 5'd6;
    step("pre_stall", 0, 0, 1, 5'd6, 64'h66, 0, 5'd0, 64'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("stall%0d", i), 0, 1, 1, 5'd13, 64'hA, 1, 5'd14, 64'hB, 0, 0);
    end
`ifdef ARB_STATS_EN
    check("stall_cnt", DW'(stall_cnt), DW'(16'd3));
    check("conflict_cnt", DW'(conflict_cnt), DW'(16'd0));
`endif
    step("stall_release", 0, 0, 1, 5'd13, 64'hA, 1, 5'd14, 64'hB, 0, 1);
`ifdef ARB_STATS_EN
    check("conflict_cnt_after", DW'(conflict_cnt), DW'(16'd1));
`endif

    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
